// File: rtl/shiftadd_iterative.sv
// rtl/shiftadd_iterative.sv - iterative shift-add reducer for 2^k-1 and 2^k+1 moduli
module shiftadd_iterative #(
    parameter int DATA_LENGTH = 64,
    parameter int BL_WIDTH    = $clog2(DATA_LENGTH + 1),
    parameter int ACC_WIDTH   = DATA_LENGTH + 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [DATA_LENGTH-1:0] x_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [BL_WIDTH-1:0]    m_bl_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   err_o,
    output logic [1:0]             mode_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FOLD, S_CORRECT, S_DONE} state_t;

    localparam logic [1:0]             MODE_NONE = 2'd0;
    localparam logic [1:0]             MODE_MERS = 2'd1;
    localparam logic [1:0]             MODE_FERM = 2'd2;
    localparam logic [BL_WIDTH-1:0]    DL_BL     = BL_WIDTH'(DATA_LENGTH);
    localparam logic [BL_WIDTH-1:0]    BL_ONE    = BL_WIDTH'(1);
    localparam logic [BL_WIDTH-1:0]    BL_TWO    = BL_WIDTH'(2);
    localparam logic [BL_WIDTH-1:0]    BL_THREE  = BL_WIDTH'(3);
    localparam logic [DATA_LENGTH:0]   ONE_W     = (DATA_LENGTH + 1)'(1);
    localparam int                     PAD       = ACC_WIDTH - DATA_LENGTH;

    state_t                       state_q, state_d;
    logic [DATA_LENGTH-1:0]       r_q, m_q;
    logic [BL_WIDTH-1:0]          bl_q, k_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         sign_q, err_q;
    logic [1:0]                   mode_q;

    logic [DATA_LENGTH:0]         mers_val, ferm_val;
    logic                         is_mers, is_ferm;
    logic [DATA_LENGTH-1:0]       mask, chunk, r_shift;
    logic signed [ACC_WIDTH-1:0]  chunk_s, m_s, fold_acc, corr_acc;
    logic                         corr_in_range;

    // Widened by one bit so that m_bl == DATA_LENGTH forms 2^m_bl without overflow.
    assign mers_val = (ONE_W << bl_q) - ONE_W;
    assign ferm_val = (ONE_W << (bl_q - BL_ONE)) + ONE_W;
    assign is_mers  = (bl_q >= BL_TWO) && (bl_q <= DL_BL) && (mers_val == {1'b0, m_q});
    assign is_ferm  = !is_mers && (bl_q >= BL_THREE) && (bl_q <= DL_BL)
                      && (ferm_val == {1'b0, m_q});

    assign mask     = ~({DATA_LENGTH{1'b1}} << k_q);
    assign chunk    = r_q & mask;
    assign chunk_s  = $signed({{PAD{1'b0}}, chunk});
    assign r_shift  = (k_q >= DL_BL) ? '0 : (r_q >> k_q);
    assign fold_acc = (mode_q == MODE_FERM && sign_q) ? acc_q - chunk_s : acc_q + chunk_s;

    assign m_s      = $signed({{PAD{1'b0}}, m_q});
    assign corr_acc = acc_q[ACC_WIDTH-1] ? acc_q + m_s :
                      (acc_q >= m_s)     ? acc_q - m_s : acc_q;
    assign corr_in_range = !corr_acc[ACC_WIDTH-1] && (corr_acc < m_s);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (valid_i) state_d = S_CHECK;
            S_CHECK:   state_d = (is_mers || is_ferm) ? S_FOLD : S_DONE;
            S_FOLD:    if (r_shift == '0) state_d = S_CORRECT;
            S_CORRECT: if (corr_in_range) state_d = S_DONE;
            S_DONE:    if (ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o  = (state_q == S_IDLE);
        busy_o   = (state_q != S_IDLE);
        valid_o  = (state_q == S_DONE);
        result_o = valid_o ? acc_q[DATA_LENGTH-1:0] : '0;
        err_o    = valid_o && err_q;
        mode_o   = valid_o ? mode_q : MODE_NONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q    <= '0;
            m_q    <= '0;
            bl_q   <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
            mode_q <= MODE_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        r_q    <= x_i;
                        m_q    <= m_i;
                        bl_q   <= m_bl_i;
                        acc_q  <= '0;
                        err_q  <= 1'b0;
                        mode_q <= MODE_NONE;
                    end
                end
                S_CHECK: begin
                    acc_q  <= '0;
                    sign_q <= 1'b0;
                    if (is_mers) begin
                        k_q    <= bl_q;
                        mode_q <= MODE_MERS;
                    end else if (is_ferm) begin
                        k_q    <= bl_q - BL_ONE;
                        mode_q <= MODE_FERM;
                    end else begin
                        err_q  <= 1'b1;
                        mode_q <= MODE_NONE;
                    end
                end
                // Fermat chunks alternate sign because 2^k == -1 (mod 2^k+1).
                S_FOLD: begin
                    acc_q  <= fold_acc;
                    r_q    <= r_shift;
                    sign_q <= ~sign_q;
                end
                S_CORRECT: acc_q <= corr_acc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftadd_iterative.sv
// tb/tb_shiftadd_iterative.sv - randomized self-checking bench for shiftadd_iterative
module tb_shiftadd_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, valid_o, ready_i, err_o, busy_o;
    logic [63:0] x_i, m_i, result_o;
    logic [6:0]  m_bl_i;
    logic [1:0]  mode_o;

    int n_checks = 0;
    int n_pass   = 0;

    shiftadd_iterative dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .x_i      (x_i),
        .m_i      (m_i),
        .m_bl_i   (m_bl_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .err_o    (err_o),
        .mode_o   (mode_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    // Reference: classification from the modulus definitions, result by plain %,
    // latency from base-2^k digit sums and how many multiples of m they are off.
    task automatic model_op(input logic [63:0] x, input logic [63:0] m, input logic [6:0] bl,
                            output logic [63:0] r, output logic e, output logic [1:0] md,
                            output int lat);
        logic [127:0]        mw, rem, d, steps;
        logic signed [127:0] acc;
        int                  k, f, blen;
        bit                  mers, ferm;
        mw   = {64'd0, m};
        mers = (bl >= 2) && (bl <= 64) && (mw == (128'd1 << bl) - 128'd1);
        ferm = !mers && (bl >= 3) && (bl <= 64) && (mw == (128'd1 << (bl - 1)) + 128'd1);
        if (!mers && !ferm) begin
            r = 64'd0; e = 1'b1; md = 2'd0; lat = 1;
        end else begin
            k = mers ? int'(bl) : int'(bl) - 1;
            blen = 0;
            for (int i = 0; i < 64; i++) if (x[i]) blen = i + 1;
            f = (blen + k - 1) / k;
            if (f < 1) f = 1;
            acc = 0;
            rem = {64'd0, x};
            for (int i = 0; i < f; i++) begin
                d   = rem % (128'd1 << k);
                acc = (ferm && (i % 2 == 1)) ? acc - $signed(d) : acc + $signed(d);
                rem = rem >> k;
            end
            steps = (acc < 0) ? (128'(-acc) + mw - 128'd1) / mw : 128'(acc) / mw;
            lat = 1 + f + ((steps < 128'd1) ? 1 : int'(steps));
            r   = x % m;
            e   = 1'b0;
            md  = mers ? 2'd1 : 2'd2;
        end
    endtask

    task automatic run_op(input logic [63:0] x, input logic [63:0] m, input logic [6:0] bl,
                          output logic [63:0] r, output logic e, output logic [1:0] md,
                          output int lat);
        @(negedge clk);
        x_i = x; m_i = m; m_bl_i = bl; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result_o; e = err_o; md = mode_o;
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [69:0] obs;
        obs = {ready_o, valid_o, busy_o, err_o, mode_o, result_o};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0})
            $display("FAIL reset_values got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [63:0] tx[4] = '{64'd100, 64'd1000, 64'd55, 64'd0};
        logic [63:0] tm[4] = '{64'd7, 64'd17, 64'd10, 64'd3};
        logic [6:0]  tb[4] = '{7'd3, 7'd5, 7'd4, 7'd2};
        logic [63:0] er[4] = '{64'd2, 64'd14, 64'd0, 64'd0};
        logic        ee[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  em[4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        int          el[4] = '{5, 5, 1, 3};
        logic [63:0] r; logic e; logic [1:0] md; int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(tx[i], tm[i], tb[i], r, e, md, lat);
            n_checks++;
            if (r !== er[i]) $display("FAIL directed%0d_result got=%0d want=%0d", i, r, er[i]);
            else n_pass++;
            n_checks++;
            if (e !== ee[i]) $display("FAIL directed%0d_err got=%0b want=%0b", i, e, ee[i]);
            else n_pass++;
            n_checks++;
            if (md !== em[i]) $display("FAIL directed%0d_mode got=%0d want=%0d", i, md, em[i]);
            else n_pass++;
            n_checks++;
            if (lat != el[i]) $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, el[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [63:0] x, m, r, xr; logic [6:0] bl; logic e, xe; logic [1:0] md, xm;
        int lat, xl, k, sel;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            x   = {$urandom, $urandom} >> $urandom_range(0, 64);
            if (sel <= 3) begin
                k  = $urandom_range(2, 64);
                m  = (k == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << k) - 64'd1;
                bl = 7'(k);
            end else if (sel <= 7) begin
                k  = $urandom_range(2, 63);
                m  = (64'd1 << k) + 64'd1;
                bl = 7'(k + 1);
            end else if (sel == 8) begin
                m  = {$urandom, $urandom} >> $urandom_range(0, 62);
                bl = 7'($urandom_range(0, 127));
            end else begin
                k  = $urandom_range(3, 40);
                m  = (64'd1 << k) - 64'd1;
                bl = 7'(k + 1);
            end
            model_op(x, m, bl, xr, xe, xm, xl);
            run_op(x, m, bl, r, e, md, lat);
            n_checks++;
            if ({r, e, md} !== {xr, xe, xm})
                $display("FAIL random%0d x=%h m=%h bl=%0d got=%h/%0b/%0d want=%h/%0b/%0d",
                         n, x, m, bl, r, e, md, xr, xe, xm);
            else n_pass++;
            n_checks++;
            if (lat != xl) $display("FAIL random%0d_latency got=%0d want=%0d", n, lat, xl);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        x_i = 64'd100; m_i = 64'd7; m_bl_i = 7'd3; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        x_i = 64'd1000; m_i = 64'd17; m_bl_i = 7'd5; valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({valid_o, ready_o, mode_o, result_o} !== {1'b1, 1'b0, 2'd1, 64'd2})
                $display("FAIL backpressure_hold%0d got=%b/%b/%0d/%0d want=1/0/1/2",
                         c, valid_o, ready_o, mode_o, result_o);
            else n_pass++;
        end
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        n_checks++;
        if ({ready_o, valid_o} !== 2'b10)
            $display("FAIL backpressure_release got=%b want=10", {ready_o, valid_o});
        else n_pass++;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if ({result_o, mode_o, err_o} !== {64'd14, 2'd2, 1'b0} || lat != 5)
            $display("FAIL backpressure_pending got=%0d/%0d/%b lat=%0d want=14/2/0 lat=5",
                     result_o, mode_o, err_o, lat);
        else n_pass++;
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] x, m, r; logic e; logic [1:0] md; int lat;
        logic [69:0] obs;
        x = 64'hFFFF_FFFF_FFFF_FFFF;
        m = (64'd1 << 61) - 64'd1;
        @(negedge clk);
        x_i = x; m_i = m; m_bl_i = 7'd61; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        obs = {ready_o, valid_o, busy_o, err_o, mode_o, result_o};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0})
            $display("FAIL reset_mid_op_values got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({ready_o, busy_o} !== 2'b10)
            $display("FAIL reset_mid_op_release got=%b want=10", {ready_o, busy_o});
        else n_pass++;
        run_op(x, m, 7'd61, r, e, md, lat);
        n_checks++;
        if ({r, e, md} !== {64'd7, 1'b0, 2'd1} || lat != 4)
            $display("FAIL reset_mid_op_reissue got=%0d/%b/%0d lat=%0d want=7/0/1 lat=4", r, e, md, lat);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        x_i = '0; m_i = '0; m_bl_i = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
